// File: rtl/cv32e40p_reg_err_collector.sv
// Parity error collector for the protected register bank.
// Masks per-register error flags, keeps sticky status, counts rising error
// events with saturation, serialises alerts over a req/ack handshake and
// latches a fatal flag once the event count reaches a threshold.
module cv32e40p_reg_err_collector #(
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned FATAL_THRESH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REGS-1:0]         err_i,
  input  logic [NUM_REGS-1:0]         err_mask_i,
  input  logic                        clear_i,
  output logic                        alert_req_o,
  input  logic                        alert_ack_i,
  output logic [$clog2(NUM_REGS)-1:0] alert_id_o,
  output logic [NUM_REGS-1:0]         err_status_o,
  output logic [CNT_WIDTH-1:0]        err_cnt_o,
  output logic                        fatal_o
);

  localparam int unsigned ID_W = $clog2(NUM_REGS);

  typedef enum logic {
    IDLE  = 1'b0,
    ALERT = 1'b1
  } state_e;

  state_e              state_q;
  logic [NUM_REGS-1:0] valid;
  logic [NUM_REGS-1:0] valid_q;
  logic [NUM_REGS-1:0] rise;
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] cand;
  logic [NUM_REGS-1:0] sel_onehot;
  logic [ID_W-1:0]     sel_id;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  assign valid = err_i & ~err_mask_i;
  assign rise  = valid & ~valid_q;
  assign cand  = pend_q | rise;

  // Lowest set index among pending and newly rising errors
  always_comb begin
    sel_id     = '0;
    sel_onehot = '0;
    for (int unsigned k = NUM_REGS; k > 0; k--) begin
      if (cand[k-1]) begin
        sel_id     = ID_W'(k-1);
        sel_onehot = '0;
        sel_onehot[k-1] = 1'b1;
      end
    end
  end

  // Next event count, saturating at all-ones
  always_comb begin
    cnt_nxt = err_cnt_o;
    if (|rise && (err_cnt_o != '1)) begin
      cnt_nxt = err_cnt_o + 1'b1;
    end
  end

  // Edge register tracks masked errors every cycle, clear cycles included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid;
    end
  end

  // Sticky status, event counter and fatal latch (fatal ignores clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_status_o <= '0;
      err_cnt_o    <= '0;
      fatal_o      <= 1'b0;
    end else if (clear_i) begin
      err_status_o <= '0;
      err_cnt_o    <= '0;
    end else begin
      err_status_o <= err_status_o | valid;
      err_cnt_o    <= cnt_nxt;
      if (cnt_nxt >= CNT_WIDTH'(FATAL_THRESH)) begin
        fatal_o <= 1'b1;
      end
    end
  end

  // Alert handshake FSM with pending-error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      alert_req_o <= 1'b0;
      alert_id_o  <= '0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      alert_req_o <= 1'b0;
      alert_id_o  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          pend_q <= cand & ~sel_onehot;
          if (|cand) begin
            state_q     <= ALERT;
            alert_id_o  <= sel_id;
            alert_req_o <= 1'b1;
          end
        end
        ALERT: begin
          pend_q <= pend_q | rise;
          if (alert_ack_i) begin
            state_q     <= IDLE;
            alert_req_o <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          alert_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
